// File: rtl/arith_cipher_engine.sv
// arith_cipher_engine: iterative add-rotate-xor block cipher.
// One DATA_W-bit word is encrypted or decrypted with a DATA_W-bit key over
// ROUNDS rounds, one round per clock, behind a start/busy/done handshake.
// The key lives in its own register, loaded in IDLE via key_load.

module arith_cipher_engine #(
  parameter int DATA_W = 16,
  parameter int ROUNDS = 4,
  parameter int ROT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  output logic              key_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out
);

  // Counter wide enough for the largest legal round count (15).
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_valid_q, key_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mode_q, mode_d;

  logic [DATA_W-1:0] rkey_s;
  logic [DATA_W-1:0] round_s;
  logic              last_s;

  // Left rotate by a run-time amount in 0..DATA_W-1 via a doubled word.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} << amt;
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

  // Round key for the current counter value, plus the per-round datapath in either direction.
  always_comb begin
    rkey_s = rotl(key_q, int'(cnt_q) % DATA_W) ^ DATA_W'(cnt_q);
    if (mode_q) begin
      // Decrypt undoes the encrypt steps in reverse: xor, rotate right, subtract.
      round_s = rotl(work_q ^ rkey_s, DATA_W - ROT) - rkey_s;
      last_s  = (cnt_q == {CNT_W{1'b0}});
    end else begin
      round_s = rotl(work_q + rkey_s, ROT) ^ rkey_s;
      last_s  = (cnt_q == CNT_W'(ROUNDS - 1));
    end
  end

  // Next-state logic for the IDLE/RUN controller and all datapath registers.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    work_d      = work_q;
    data_out_d  = data_out_q;
    cnt_d       = cnt_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          // A key load wins over a start in the same cycle.
          key_d       = key_in;
          key_valid_d = 1'b1;
        end else if (start && key_valid_q) begin
          work_d  = data_in;
          mode_d  = mode;
          cnt_d   = mode ? CNT_W'(ROUNDS - 1) : {CNT_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start and key_load are deliberately not looked at here.
        work_d = round_s;
        if (last_s) begin
          data_out_d = round_s;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = {CNT_W{1'b0}};
          state_d    = ST_IDLE;
        end else if (mode_q) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      key_q       <= {DATA_W{1'b0}};
      work_q      <= {DATA_W{1'b0}};
      data_out_q  <= {DATA_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      work_q      <= work_d;
      data_out_q  <= data_out_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
    end
  end

  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_arith_cipher_engine.sv
// Scoreboard bench for arith_cipher_engine: a default-parameter instance (A)
// and a DATA_W=8/ROUNDS=1/ROT=1 instance (B). Stimulus pushes expected results
// into per-instance queues; monitors pop and compare whenever done is seen.

module tb_arith_cipher_engine;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        a_key_load, a_start, a_mode;
  logic [15:0] a_key_in, a_data_in, a_data_out;
  logic        a_key_valid, a_busy, a_done;

  logic        b_key_load, b_start, b_mode;
  logic [7:0]  b_key_in, b_data_in, b_data_out;
  logic        b_key_valid, b_busy, b_done;

  int total = 0;
  int bad   = 0;

  logic [15:0] qa[$];
  logic [7:0]  qb[$];
  logic        a_prev_done = 1'b0;
  logic        b_prev_done = 1'b0;

  arith_cipher_engine #(.DATA_W(16), .ROUNDS(4), .ROT(3)) u_a (
    .clk(clk), .rst_n(rst_n), .key_load(a_key_load), .key_in(a_key_in),
    .start(a_start), .mode(a_mode), .data_in(a_data_in),
    .key_valid(a_key_valid), .busy(a_busy), .done(a_done), .data_out(a_data_out)
  );

  arith_cipher_engine #(.DATA_W(8), .ROUNDS(1), .ROT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .key_load(b_key_load), .key_in(b_key_in),
    .start(b_start), .mode(b_mode), .data_in(b_data_in),
    .key_valid(b_key_valid), .busy(b_busy), .done(b_done), .data_out(b_data_out)
  );

  // Reference model: plain modular arithmetic on a w-bit word held in 32 bits.
  function automatic logic [31:0] m_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] m_rotl(input logic [31:0] v, input int a, input int w);
    logic [31:0] m;
    int          s;
    m = m_mask(w);
    s = a % w;
    if (s == 0) return v & m;
    return (((v & m) << s) | ((v & m) >> (w - s))) & m;
  endfunction

  function automatic logic [31:0] m_cipher(input logic [31:0] key, input logic [31:0] data,
                                           input bit dec, input int w, input int rounds,
                                           input int rot);
    logic [31:0] x, k, m;
    m = m_mask(w);
    x = data & m;
    if (!dec) begin
      for (int i = 0; i < rounds; i++) begin
        k = m_rotl(key, i, w) ^ 32'(i);
        x = m_rotl((x + k) & m, rot, w) ^ k;
      end
    end else begin
      for (int i = rounds - 1; i >= 0; i--) begin
        k = m_rotl(key, i, w) ^ 32'(i);
        x = (m_rotl(x ^ k, w - rot, w) - k) & m;
      end
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor A: every done pops one expected result; done must never last two cycles.
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (qa.size() == 0) fail_now("a_unexpected_done");
      else chk("a_result", {16'h0, a_data_out}, {16'h0, qa.pop_front()});
      chk("a_done_width", {31'h0, a_prev_done}, 32'h0);
    end
    a_prev_done <= a_done;
  end

  // Monitor B: same scoreboard scheme for the 8-bit instance.
  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      if (qb.size() == 0) fail_now("b_unexpected_done");
      else chk("b_result", {24'h0, b_data_out}, {24'h0, qb.pop_front()});
      chk("b_done_width", {31'h0, b_prev_done}, 32'h0);
    end
    b_prev_done <= b_done;
  end

  task automatic a_load(input logic [15:0] k);
    a_key_in   = k;
    a_key_load = 1'b1;
    @(posedge clk); #1;
    a_key_load = 1'b0;
  endtask

  task automatic b_load(input logic [7:0] k);
    b_key_in   = k;
    b_key_load = 1'b1;
    @(posedge clk); #1;
    b_key_load = 1'b0;
  endtask

  // Wait (bounded) for done on A, counting busy cycles seen on the way.
  task automatic a_wait(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_done) begin
        seen = 1'b1;
        break;
      end
      if (a_busy) busy_cycles++;
    end
    if (!seen) begin
      fail_now("a_timeout");
      qa.delete();
    end
  endtask

  task automatic a_op(input logic [15:0] d, input bit m, input logic [15:0] exp,
                      output int busy_cycles);
    a_data_in = d;
    a_mode    = m;
    a_start   = 1'b1;
    qa.push_back(exp);
    @(posedge clk); #1;
    a_start = 1'b0;
    a_wait(busy_cycles);
  endtask

  task automatic b_op(input logic [7:0] d, input bit m, input logic [7:0] exp);
    bit seen;
    b_data_in = d;
    b_mode    = m;
    b_start   = 1'b1;
    qb.push_back(exp);
    @(posedge clk); #1;
    b_start = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now("b_timeout");
      qb.delete();
    end
  endtask

  initial begin
    int          bc;
    int          busy_seen;
    logic [15:0] k16, d16, e16;
    logic [7:0]  k8, d8, e8;

    rst_n = 1'b0;
    a_key_load = 1'b0; a_start = 1'b0; a_mode = 1'b0; a_key_in = 16'h0; a_data_in = 16'h0;
    b_key_load = 1'b0; b_start = 1'b0; b_mode = 1'b0; b_key_in = 8'h0;  b_data_in = 8'h0;
    #23;
    chk("rst_busy",      {31'h0, a_busy},      32'h0);
    chk("rst_done",      {31'h0, a_done},      32'h0);
    chk("rst_key_valid", {31'h0, a_key_valid}, 32'h0);
    chk("rst_data_out",  {16'h0, a_data_out},  32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Start with no key loaded must be ignored.
    a_data_in = 16'h0001; a_mode = 1'b0; a_start = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_busy) busy_seen++;
    end
    a_start = 1'b0;
    chk("nokey_busy",     32'(busy_seen),       32'h0);
    chk("nokey_data_out", {16'h0, a_data_out},  32'h0);

    // key_load and start together: key taken, no operation.
    a_key_in = 16'h0000; a_key_load = 1'b1; a_start = 1'b1;
    @(posedge clk); #1;
    a_key_load = 1'b0; a_start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_busy) busy_seen++;
    end
    chk("kl_start_key_valid", {31'h0, a_key_valid}, 32'h1);
    chk("kl_start_busy",      32'(busy_seen),        32'h0);

    // Known-answer vectors with key 0; back-to-back starts overlap done.
    a_op(16'h0001, 1'b0, 16'h12EB, bc);
    chk("busy_cycles", 32'(bc), 32'd4);
    a_op(16'hFFFF, 1'b0, 16'h00EB, bc);
    a_op(16'h12EB, 1'b1, 16'h0001, bc);
    chk("dec_busy_cycles", 32'(bc), 32'd4);

    // start/key_load pulsed during RUN must not disturb the operation.
    a_data_in = 16'h1234; a_mode = 1'b0; a_start = 1'b1;
    qa.push_back(16'(m_cipher(32'h0, 32'h1234, 1'b0, 16, 4, 3)));
    @(posedge clk); #1;
    a_start = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b1; a_key_load = 1'b1; a_key_in = 16'h5A5A; a_data_in = 16'hFFFF; a_mode = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_key_load = 1'b0;
    a_wait(bc);
    chk("run_key_valid", {31'h0, a_key_valid}, 32'h1);
    a_op(16'h0001, 1'b0, 16'h12EB, bc);

    // Reset two cycles into RUN clears everything at once.
    a_data_in = 16'h4321; a_mode = 1'b0; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",      {31'h0, a_busy},      32'h0);
    chk("mid_rst_done",      {31'h0, a_done},      32'h0);
    chk("mid_rst_key_valid", {31'h0, a_key_valid}, 32'h0);
    chk("mid_rst_data_out",  {16'h0, a_data_out},  32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_data_in = 16'h0001; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (a_busy) busy_seen++;
    end
    chk("post_rst_busy", 32'(busy_seen), 32'h0);

    // Random round trips on A.
    for (int n = 0; n < 200; n++) begin
      k16 = 16'($urandom);
      d16 = 16'($urandom);
      e16 = 16'(m_cipher(32'(k16), 32'(d16), 1'b0, 16, 4, 3));
      a_load(k16);
      a_op(d16, 1'b0, e16, bc);
      a_op(e16, 1'b1, d16, bc);
    end

    // Random round trips on B.
    for (int n = 0; n < 200; n++) begin
      k8 = 8'($urandom);
      d8 = 8'($urandom);
      e8 = 8'(m_cipher(32'(k8), 32'(d8), 1'b0, 8, 1, 1));
      b_load(k8);
      b_op(d8, 1'b0, e8);
      b_op(e8, 1'b1, d8);
    end

    repeat (3) @(negedge clk);
    chk("a_queue_empty", 32'(qa.size()), 32'h0);
    chk("b_queue_empty", 32'(qb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
